m68k_fpga_bridge: RTL and testbench
===================================

# m68k_fpga_bridge

Bus bridge between the 68040 local bus and the FPGA register port. It decodes 68040 transfer starts into a fixed address window and issues one single-cycle strobe per access on the `fpga_stb/fpga_ack` register port consumed by `fpga_int`. It terminates the CPU cycle with TA on acknowledge, or with TEA on timeout or an unsupported size. It also returns read data onto the CPU data bus.

## Interface
- `SEL_HI`, default 16'hFFF0: value compared against `cpu_addr[31:16]` to select the window.
- `TIMEOUT`, default 16: cycles spent in WAIT without ack before TEA; legal range 2..255.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  bus clock, the same clock as `fpga_int`.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_ts_n`  in  1  transfer start, low for one clock.
- `cpu_rw`  in  1  1 = read, 0 = write.
- `cpu_siz`  in  2  transfer size: 00 long, 01 byte, 10 word, 11 line.
- `cpu_addr`  in  32  address, valid while TS is low.
- `cpu_data_in`  in  32  write data, valid the clock after TS.
- `cpu_data_out`  out  32  registered read data.
- `cpu_data_oe`  out  1  data bus drive enable, read termination only.
- `cpu_ta_n`  out  1  transfer acknowledge.
- `cpu_tea_n`  out  1  transfer error acknowledge.
- `fpga_stb`  out  1  register strobe, one-clock pulse.
- `fpga_ack`  in  1  level acknowledge from the register port.
- `fpga_addr`  out  4  register index.
- `fpga_data`  out  8  write byte.
- `fpga_we`  out  1  1 = write access.
- `fpga_odata`  in  32  read data from the register port.

## Operation
- States: IDLE, WDATA, STROBE, WAIT, TERM, ERR.
- **IDLE:** a hit is `cpu_ts_n`=0 and `cpu_addr[31:16]`=`SEL_HI`. On a hit:
  - latch `fpga_addr` from `cpu_addr[5:2]`; addresses alias within the window;
  - latch `fpga_we` as `~cpu_rw`;
  - latch the size and `cpu_addr[1:0]`;
  - SIZ=11 → ERR, with no strobe;
  - write → WDATA; read → STROBE.
- Misses and TS while not IDLE are ignored.
- **WDATA:** latch `fpga_data` from `cpu_data_in`.
  - Byte size: lane chosen by A[1:0]: 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - Long and word sizes: [7:0].
  - Next state → STROBE.
- **STROBE:** `fpga_stb`=1 for exactly this clock, then → WAIT. Timeout counter cleared.
- **WAIT:** `fpga_ack` is sampled only here. A stale high ack before or during STROBE is never used.
  - ack=1 → TERM; a read also latches `fpga_odata` into `cpu_data_out`.
  - Otherwise the counter increments; counter = `TIMEOUT`-1 without ack → ERR.
- **TERM:** `cpu_ta_n`=0 for one clock. `cpu_data_oe`=1 for the same clock on reads. Next state → IDLE.
- **ERR:** `cpu_tea_n`=0 for one clock, TA stays high, `cpu_data_oe`=0. Next state → IDLE.
- All control outputs are registered, decoded from the next state. TA and TEA are never low together.

## Timing
- Reset values: state IDLE, `cpu_ta_n`=1, `cpu_tea_n`=1, `cpu_data_oe`=0, `fpga_stb`=0, `fpga_we`=0, `fpga_addr`=0, `fpga_data`=0, `cpu_data_out`=0, counter 0.
- Read, TS sampled in cycle N:
  - STROBE in N+1; WAIT from N+2.
  - With `fpga_int` (ack high in N+3): TA low in N+4.
- Write: same as read plus one clock; TA low in N+5.
- Timeout: TEA low exactly `TIMEOUT`+1 clocks after the STROBE cycle.
- Reset asserted mid-transfer: outputs return to reset values immediately (async) and no TA/TEA is issued. After release the next TS starts cleanly.
- `fpga_addr`, `fpga_data` and `fpga_we` hold stable from STROBE until the next hit.
- Back-to-back TS: a hit in the clock after TERM or ERR is accepted.

## Structure
- Shared package `m68k_bus_pkg`:
  - state enum;
  - SIZ encodings (`SIZ_LONG`, `SIZ_BYTE`, `SIZ_WORD`, `SIZ_LINE`);
  - default `SEL_HI`.
- Sub-module `bus_timeout`: 8-bit counter with clear, enable, and `expired` = (count == `TIMEOUT`-1).
- Lane select stays inline.

## Test plan
- Read at 0xFFF0_0010 with `fpga_int` as the target returning 0x0000_0000 → one `fpga_stb` pulse with `fpga_addr`=4; `cpu_ta_n` low in N+4; `cpu_data_oe`=1 for that clock only.
- Byte write of 0x05 at 0xFFF0_0013, lane [7:0] → `fpga_addr`=4, `fpga_data`=0x05, `fpga_we`=1 → `fpga_int` drives `out_ipl`=3'b010 during the strobe; TA in N+5.
- Ack tied low, `TIMEOUT`=16 → `cpu_tea_n` low 17 clocks after STROBE; no TA; state returns to IDLE.
- SIZ=11 read in window → TEA in N+1, `fpga_stb` never asserted; TS at 0x1000_0000 → no response at all.
- Reset asserted during WAIT → all outputs at reset values within the same clock. A following read then completes normally with TA in N+4.
- Ack held high before the strobe (stale) → TA still not issued before N+4.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68040 local bus to FPGA register port bridge:
// FSM state encoding, 68040 SIZ encodings, bus widths and default window.
package m68k_bus_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned SIZ_W   = 2;
  localparam int unsigned CNT_W   = 8;

  // 68040 SIZ[1:0] transfer size encodings
  localparam logic [SIZ_W-1:0] SIZ_LONG = 2'b00;
  localparam logic [SIZ_W-1:0] SIZ_BYTE = 2'b01;
  localparam logic [SIZ_W-1:0] SIZ_WORD = 2'b10;
  localparam logic [SIZ_W-1:0] SIZ_LINE = 2'b11;

  // Default value of cpu_addr[31:16] that selects the register window
  localparam logic [15:0] SEL_HI_DEFAULT = 16'hFFF0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_STROBE = 3'd2,
    S_WAIT   = 3'd3,
    S_TERM   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

endpackage

// File: rtl/bus_timeout.sv
// Wait-state timeout counter for the bridge.
// Ports: clk, rst (async active-low), clr (synchronous clear), en (count
// enable), expired (count has reached TIMEOUT-1).
module bus_timeout
  import m68k_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Clear has priority so a new strobe always restarts the budget
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/m68k_fpga_bridge.sv
// Bridge from the 68040 local bus to the FPGA register port.
// Decodes transfer starts in the SEL_HI window, issues one fpga_stb pulse per
// access, waits for fpga_ack (with timeout) and terminates with TA or TEA.
// Ports:
//   clk, rst                       clock, async active-low reset
//   cpu_ts_n/rw/siz/addr/data_in   68040 transfer request
//   cpu_data_out/data_oe           read data and its drive enable
//   cpu_ta_n/tea_n                 cycle termination
//   fpga_stb/ack/addr/data/we/odata register port
module m68k_fpga_bridge
  import m68k_bus_pkg::*;
#(
  parameter logic [15:0] SEL_HI  = SEL_HI_DEFAULT,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ts_n,
  input  logic              cpu_rw,
  input  logic [SIZ_W-1:0]  cpu_siz,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data_in,
  output logic [DATA_W-1:0] cpu_data_out,
  output logic              cpu_data_oe,
  output logic              cpu_ta_n,
  output logic              cpu_tea_n,
  output logic              fpga_stb,
  input  logic              fpga_ack,
  output logic [REG_W-1:0]  fpga_addr,
  output logic [BYTE_W-1:0] fpga_data,
  output logic              fpga_we,
  input  logic [DATA_W-1:0] fpga_odata
);

  state_t             state, state_d;
  logic [SIZ_W-1:0]   siz_q, siz_d;
  logic [1:0]         a_lo_q, a_lo_d;
  logic [REG_W-1:0]   addr_d;
  logic [BYTE_W-1:0]  data_d;
  logic               we_d;
  logic [DATA_W-1:0]  rdata_d;
  logic               stb_d, ta_n_d, tea_n_d, oe_d;
  logic               tmo_clr, tmo_en, tmo_expired;
  logic               hit;

  // Address bits between the register index and the window select alias
  logic unused_addr;
  assign unused_addr = ^cpu_addr[15:6];

  assign hit = !cpu_ts_n && (cpu_addr[31:16] == SEL_HI);

  bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      siz_q        <= SIZ_LONG;
      a_lo_q       <= 2'b00;
      fpga_addr    <= '0;
      fpga_data    <= '0;
      fpga_we      <= 1'b0;
      fpga_stb     <= 1'b0;
      cpu_data_out <= '0;
      cpu_data_oe  <= 1'b0;
      cpu_ta_n     <= 1'b1;
      cpu_tea_n    <= 1'b1;
    end else begin
      state        <= state_d;
      siz_q        <= siz_d;
      a_lo_q       <= a_lo_d;
      fpga_addr    <= addr_d;
      fpga_data    <= data_d;
      fpga_we      <= we_d;
      fpga_stb     <= stb_d;
      cpu_data_out <= rdata_d;
      cpu_data_oe  <= oe_d;
      cpu_ta_n     <= ta_n_d;
      cpu_tea_n    <= tea_n_d;
    end
  end

  // Next state, latched transfer attributes and output decode
  always_comb begin
    state_d = state;
    siz_d   = siz_q;
    a_lo_d  = a_lo_q;
    addr_d  = fpga_addr;
    data_d  = fpga_data;
    we_d    = fpga_we;
    rdata_d = cpu_data_out;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (hit) begin
          addr_d = cpu_addr[5:2];
          we_d   = ~cpu_rw;
          siz_d  = cpu_siz;
          a_lo_d = cpu_addr[1:0];
          if (cpu_siz == SIZ_LINE) begin
            state_d = S_ERR;
          end else if (!cpu_rw) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_STROBE;
          end
        end
      end
      S_WDATA: begin
        // Big-endian byte lanes: A[1:0]=0 is the most significant byte
        if (siz_q == SIZ_BYTE) begin
          unique case (a_lo_q)
            2'd0:    data_d = cpu_data_in[31:24];
            2'd1:    data_d = cpu_data_in[23:16];
            2'd2:    data_d = cpu_data_in[15:8];
            default: data_d = cpu_data_in[7:0];
          endcase
        end else begin
          data_d = cpu_data_in[7:0];
        end
        state_d = S_STROBE;
      end
      S_STROBE: begin
        tmo_clr = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ack is only looked at here, so a stale level from before the strobe is ignored
        if (fpga_ack) begin
          state_d = S_TERM;
          if (!fpga_we) begin
            rdata_d = fpga_odata;
          end
        end else if (tmo_expired) begin
          state_d = S_ERR;
        end else begin
          tmo_en = 1'b1;
        end
      end
      S_TERM:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    stb_d   = (state_d == S_STROBE);
    ta_n_d  = (state_d != S_TERM);
    tea_n_d = (state_d != S_ERR);
    oe_d    = (state_d == S_TERM) && !we_d;
  end

endmodule

// File: tb/tb_m68k_fpga_bridge.sv
// Directed scoreboard bench for m68k_fpga_bridge with a small register-port
// responder that acknowledges two clocks after each strobe.
module tb_m68k_fpga_bridge;

  localparam int K_NONE = 0;
  localparam int K_TA   = 1;
  localparam int K_TEA  = 2;
  localparam logic [15:0] WIN = 16'hFFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ts_n;
  logic        cpu_rw;
  logic [1:0]  cpu_siz;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data_in;
  logic [31:0] cpu_data_out;
  logic        cpu_data_oe;
  logic        cpu_ta_n;
  logic        cpu_tea_n;
  logic        fpga_stb;
  logic        fpga_ack;
  logic [3:0]  fpga_addr;
  logic [7:0]  fpga_data;
  logic        fpga_we;
  logic [31:0] fpga_odata;

  logic ack_en;
  logic stale;
  logic ack_d1, ack_d2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          kind;
    int          lat;
    logic        rd;
    logic [31:0] rdata;
    int          nstb;
    logic [3:0]  addr;
    logic        we;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];

  m68k_fpga_bridge #(
    .SEL_HI  (WIN),
    .TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_ts_n     (cpu_ts_n),
    .cpu_rw       (cpu_rw),
    .cpu_siz      (cpu_siz),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_data_out (cpu_data_out),
    .cpu_data_oe  (cpu_data_oe),
    .cpu_ta_n     (cpu_ta_n),
    .cpu_tea_n    (cpu_tea_n),
    .fpga_stb     (fpga_stb),
    .fpga_ack     (fpga_ack),
    .fpga_addr    (fpga_addr),
    .fpga_data    (fpga_data),
    .fpga_we      (fpga_we),
    .fpga_odata   (fpga_odata)
  );

  always #5 clk = ~clk;

  // Register-port responder: ack is high in the second clock after the strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_d1 <= 1'b0;
      ack_d2 <= 1'b0;
    end else begin
      ack_d1 <= fpga_stb & ack_en;
      ack_d2 <= ack_d1;
    end
  end
  assign fpga_ack = ack_d2 | stale;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // One CPU transfer: TS driven in cycle N, outputs sampled at negedges N+k
  task automatic xfer(input logic rw, input logic [1:0] siz, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] odat,
                      input int kind, input int lat, input logic [7:0] edata,
                      input bit stale_ack, input bit stray_ts);
    exp_t e, g;
    int k, budget, got_kind, got_lat, nstb;
    logic got_oe;
    logic [31:0] got_rdata;
    logic [3:0] s_addr, t_addr;
    logic s_we;
    logic [7:0] s_data;
    e.kind  = kind;
    e.lat   = lat;
    e.rd    = rw;
    e.rdata = odat;
    e.nstb  = ((addr[31:16] == WIN) && (siz != 2'b11)) ? 1 : 0;
    e.addr  = addr[5:2];
    e.we    = ~rw;
    e.data  = edata;
    sb.push_back(e);

    @(negedge clk);
    chk("pre_ta_n", 32'(cpu_ta_n), 32'd1);
    chk("pre_oe", 32'(cpu_data_oe), 32'd0);
    cpu_ts_n   = 1'b0;
    cpu_rw     = rw;
    cpu_siz    = siz;
    cpu_addr   = addr;
    fpga_odata = odat;
    stale      = stale_ack;
    @(negedge clk);
    cpu_ts_n    = 1'b1;
    cpu_data_in = wdata;
    cpu_addr    = 32'h0;
    cpu_rw      = ~rw;
    cpu_siz     = 2'b11;

    budget   = (kind == K_NONE) ? 10 : 40;
    k        = 1;
    got_kind = K_NONE;
    got_lat  = 0;
    nstb     = 0;
    got_oe   = 1'b0;
    got_rdata = '0;
    s_addr = '0; s_we = 1'b0; s_data = '0; t_addr = '0;
    while (k <= budget && got_kind == K_NONE) begin
      if (stale_ack && k == 2) stale = 1'b0;
      if (stray_ts) begin
        cpu_ts_n = (k == 2) ? 1'b0 : 1'b1;
        cpu_addr = (k == 2) ? {WIN, 16'h0000} : 32'h0;
      end
      chk("ta_tea_excl", 32'(cpu_ta_n | cpu_tea_n), 32'd1);
      if (fpga_stb) begin
        nstb++;
        s_addr = fpga_addr;
        s_we   = fpga_we;
        s_data = fpga_data;
      end
      if (!cpu_ta_n) begin
        got_kind = K_TA;
      end else if (!cpu_tea_n) begin
        got_kind = K_TEA;
      end
      if (got_kind != K_NONE) begin
        got_lat   = k;
        got_oe    = cpu_data_oe;
        got_rdata = cpu_data_out;
        t_addr    = fpga_addr;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    cpu_ts_n = 1'b1;

    g = sb.pop_front();
    chk("term_kind", 32'(got_kind), 32'(g.kind));
    chk("term_latency", 32'(got_lat), (g.kind == K_NONE) ? 32'd0 : 32'(g.lat));
    chk("strobe_count", 32'(nstb), 32'(g.nstb));
    if (g.nstb == 1) begin
      chk("stb_addr", 32'(s_addr), 32'(g.addr));
      chk("stb_we", 32'(s_we), 32'(g.we));
      if (g.we) chk("stb_data", 32'(s_data), 32'(g.data));
    end
    if (g.kind == K_TA) begin
      chk("term_oe", 32'(got_oe), 32'(g.rd));
      chk("addr_hold", 32'(t_addr), 32'(g.addr));
      if (g.rd) chk("read_data", got_rdata, g.rdata);
    end else if (g.kind == K_TEA) begin
      chk("err_oe", 32'(got_oe), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    cpu_ts_n    = 1'b1;
    cpu_rw      = 1'b1;
    cpu_siz     = 2'b00;
    cpu_addr    = '0;
    cpu_data_in = '0;
    fpga_odata  = '0;
    ack_en      = 1'b1;
    stale       = 1'b0;

    #12;
    chk("rst_ta_n", 32'(cpu_ta_n), 32'd1);
    chk("rst_tea_n", 32'(cpu_tea_n), 32'd1);
    chk("rst_oe", 32'(cpu_data_oe), 32'd0);
    chk("rst_stb", 32'(fpga_stb), 32'd0);
    chk("rst_we", 32'(fpga_we), 32'd0);
    chk("rst_addr", 32'(fpga_addr), 32'd0);
    chk("rst_data", 32'(fpga_data), 32'd0);
    chk("rst_rdata", cpu_data_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // rw, siz, addr, wdata, odata, kind, latency, expected byte, stale, stray
    xfer(1'b1, 2'b00, 32'hFFF0_0010, 32'h0, 32'h0000_0000, K_TA, 4, 8'h00, 1'b0, 1'b0);
    xfer(1'b0, 2'b01, 32'hFFF0_0013, 32'h0000_0005, 32'h0, K_TA, 5, 8'h05, 1'b0, 1'b1);
    xfer(1'b1, 2'b00, 32'hFFF0_0008, 32'h0, 32'hDEAD_BEEF, K_TA, 4, 8'h00, 1'b0, 1'b1);
    xfer(1'b0, 2'b01, 32'hFFF0_0020, 32'hAABB_CCDD, 32'h0, K_TA, 5, 8'hAA, 1'b0, 1'b0);
    xfer(1'b0, 2'b01, 32'hFFF0_0021, 32'hAABB_CCDD, 32'h0, K_TA, 5, 8'hBB, 1'b0, 1'b0);
    xfer(1'b0, 2'b01, 32'hFFF0_0022, 32'hAABB_CCDD, 32'h0, K_TA, 5, 8'hCC, 1'b0, 1'b0);
    xfer(1'b0, 2'b10, 32'hFFF0_0006, 32'h1122_3344, 32'h0, K_TA, 5, 8'h44, 1'b0, 1'b0);
    xfer(1'b0, 2'b00, 32'hFFF0_003C, 32'h1234_5678, 32'h0, K_TA, 5, 8'h78, 1'b0, 1'b0);
    xfer(1'b1, 2'b11, 32'hFFF0_0004, 32'h0, 32'h0, K_TEA, 1, 8'h00, 1'b0, 1'b0);
    xfer(1'b1, 2'b00, 32'h1000_0000, 32'h0, 32'h0, K_NONE, 0, 8'h00, 1'b0, 1'b0);
    xfer(1'b1, 2'b00, 32'hFFF0_FF44, 32'h0, 32'h0BAD_F00D, K_TA, 4, 8'h00, 1'b0, 1'b0);

    // No acknowledge: TEA TIMEOUT+1 clocks after the strobe in N+1
    ack_en = 1'b0;
    xfer(1'b1, 2'b00, 32'hFFF0_000C, 32'h0, 32'h0, K_TEA, 18, 8'h00, 1'b0, 1'b0);
    ack_en = 1'b1;

    // Stale ack high through IDLE and STROBE must not shorten the read
    xfer(1'b1, 2'b00, 32'hFFF0_0018, 32'h0, 32'h5555_AAAA, K_TA, 4, 8'h00, 1'b1, 1'b0);

    // Reset during WAIT of a read that would otherwise time out
    ack_en = 1'b0;
    @(negedge clk);
    cpu_ts_n = 1'b0;
    cpu_rw   = 1'b1;
    cpu_siz  = 2'b00;
    cpu_addr = 32'hFFF0_0024;
    fpga_odata = 32'h0;
    @(negedge clk);
    cpu_ts_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_ta_n", 32'(cpu_ta_n), 32'd1);
    chk("mid_rst_tea_n", 32'(cpu_tea_n), 32'd1);
    chk("mid_rst_oe", 32'(cpu_data_oe), 32'd0);
    chk("mid_rst_stb", 32'(fpga_stb), 32'd0);
    chk("mid_rst_we", 32'(fpga_we), 32'd0);
    chk("mid_rst_addr", 32'(fpga_addr), 32'd0);
    chk("mid_rst_data", 32'(fpga_data), 32'd0);
    chk("mid_rst_rdata", cpu_data_out, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_rst_term", 32'({cpu_ta_n, cpu_tea_n}), 32'd3);
    end
    rst    = 1'b1;
    ack_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({cpu_ta_n, cpu_tea_n}), 32'd3);
    end
    xfer(1'b1, 2'b00, 32'hFFF0_0024, 32'h0, 32'hCAFE_0123, K_TA, 4, 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    chk("final_ta_n", 32'(cpu_ta_n), 32'd1);
    chk("final_oe", 32'(cpu_data_oe), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
